// File: rtl/histogram_accumulator_pkg.sv
// Shared types and sizes for the luminance histogram and the cumulative stage.
package histogram_accumulator_pkg;

    localparam int NUM_BINS        = 256;
    localparam int HIST_NUM_PIXELS = 384000;
    localparam int HIST_WORD_SIZE  = 20;

    typedef enum logic [2:0] {
        CLEAR,
        WAIT_FRAME,
        ACCUM,
        DRAIN,
        HANDOFF,
        WAIT_CUM
    } hist_state_t;

endpackage

// File: rtl/histogram_accumulator_if.sv
// Histogram RAM bus: read address/data and registered write port.
interface histogram_accumulator_if
    import histogram_accumulator_pkg::*;
#(
    parameter int WORD_SIZE = HIST_WORD_SIZE
);
    logic [7:0]           oAddrRd;
    logic [WORD_SIZE-1:0] iQ;
    logic [7:0]           oAddrWr;
    logic [WORD_SIZE-1:0] oDataWr;
    logic                 oWE;

    modport master (
        output oAddrRd, oAddrWr, oDataWr, oWE,
        input  iQ
    );

    modport slave (
        input  oAddrRd, oAddrWr, oDataWr, oWE,
        output iQ
    );
endinterface

// File: rtl/histogram_accumulator_rmw.sv
// Read / increment / write pipeline for histogram bins. The RAM returns data
// one cycle after the address, and a write lands one cycle after it is
// presented, so the two most recent writes are forwarded into the increment.
module hist_rmw_pipe
    import histogram_accumulator_pkg::*;
#(
    parameter int WORD_SIZE = HIST_WORD_SIZE
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 flush,
    input  logic                 pix_valid,
    input  logic [7:0]           pix,
    input  logic                 clr_en,
    input  logic [7:0]           clr_addr,
    input  logic [WORD_SIZE-1:0] q,
    output logic [7:0]           addr_rd,
    output logic [7:0]           addr_wr,
    output logic [WORD_SIZE-1:0] data_wr,
    output logic                 we
);
    localparam logic [WORD_SIZE-1:0] CNT_MAX = '1;

    logic                 v1;
    logic                 v2;
    logic [7:0]           a2;
    logic                 prev_we;
    logic [7:0]           prev_addr;
    logic [WORD_SIZE-1:0] prev_data;
    logic [WORD_SIZE-1:0] base;
    logic [WORD_SIZE-1:0] cnt_inc;

    // Pick the freshest value of the bin: newest write wins over older write over RAM.
    always_comb begin
        base = q;
        if (prev_we && (prev_addr == a2)) base = prev_data;
        if (we && (addr_wr == a2))        base = data_wr;
        cnt_inc = (base == CNT_MAX) ? base : base + 1'b1;
    end

    // Pipeline registers; clear writes share the write port with pixel updates.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            a2        <= '0;
            addr_rd   <= '0;
            addr_wr   <= '0;
            data_wr   <= '0;
            we        <= 1'b0;
            prev_we   <= 1'b0;
            prev_addr <= '0;
            prev_data <= '0;
        end else begin
            prev_we   <= we;
            prev_addr <= addr_wr;
            prev_data <= data_wr;
            if (flush) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
            end else begin
                v1 <= pix_valid;
                v2 <= v1;
            end
            if (pix_valid) addr_rd <= pix;
            a2 <= addr_rd;
            if (clr_en) begin
                we      <= 1'b1;
                addr_wr <= clr_addr;
                data_wr <= '0;
            end else if (v2 && !flush) begin
                we      <= 1'b1;
                addr_wr <= a2;
                data_wr <= cnt_inc;
            end else begin
                we      <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/histogram_accumulator.sv
// Frame-level control for the luminance histogram: clear, count one frame,
// hand the RAM to the cumulative stage, wait for it, then re-arm.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// CLEAR      | zeroing bins 0..255, one per cycle
// WAIT_FRAME | idle, waiting for a frame start pulse
// ACCUM      | counting pixels of the current frame
// DRAIN      | letting the last read-modify-write retire (3 cycles)
// HANDOFF    | RAM released, start pulse to cumulative stage
// WAIT_CUM   | RAM released, waiting for cumulative stage done
module histogram_accumulator
    import histogram_accumulator_pkg::*;
#(
    parameter int WORD_SIZE  = HIST_WORD_SIZE,
    parameter int NUM_PIXELS = HIST_NUM_PIXELS,
    parameter int CNT_W      = 19
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iFrameStart,
    input  logic                     iPixValid,
    input  logic [7:0]               iPixel,
    histogram_accumulator_if.master  ram,
    output logic                     oOwnRam,
    output logic                     oStartCum,
    input  logic                     iCumDone,
    output logic                     oCumRestart,
    output logic                     oFrameErr,
    output logic                     oBusy
);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [7:0]       LAST_BIN = 8'(NUM_BINS - 1);

    hist_state_t          state_q;
    hist_state_t          state_d;
    logic [7:0]           clr_addr_q;
    logic [CNT_W-1:0]     pix_cnt_q;
    logic [1:0]           drain_cnt_q;
    logic                 frame_err_q;
    logic                 cum_restart_q;
    logic                 accept;
    logic                 abort;
    logic [7:0]           addr_rd;
    logic [7:0]           addr_wr;
    logic [WORD_SIZE-1:0] data_wr;
    logic                 we;

    // Next-state decode plus pixel accept / frame abort qualification.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == LAST_BIN) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (iFrameStart) begin
                    state_d = ACCUM;
                    accept  = iPixValid;
                end
            end
            ACCUM: begin
                if (iFrameStart) begin
                    abort   = 1'b1;
                    state_d = CLEAR;
                end else if (iPixValid) begin
                    accept = 1'b1;
                    if (pix_cnt_q == LAST_PIX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 2'd0) state_d = HANDOFF;
            end
            HANDOFF: begin
                state_d = WAIT_CUM;
            end
            WAIT_CUM: begin
                if (iCumDone) state_d = CLEAR;
            end
            default: state_d = CLEAR;
        endcase
    end

    // State register, clear address, pixel count, drain timer and pulses.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q       <= CLEAR;
            clr_addr_q    <= '0;
            pix_cnt_q     <= '0;
            drain_cnt_q   <= 2'd2;
            frame_err_q   <= 1'b0;
            cum_restart_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= (state_q == CLEAR) ? clr_addr_q + 8'd1 : 8'd0;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q - 2'd1 : 2'd2;
            if (state_q == WAIT_FRAME) begin
                pix_cnt_q <= {{(CNT_W-1){1'b0}}, accept};
            end else if (accept) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end
            frame_err_q   <= abort;
            cum_restart_q <= (state_q == WAIT_CUM) && iCumDone;
        end
    end

    hist_rmw_pipe #(
        .WORD_SIZE (WORD_SIZE)
    ) u_rmw (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .flush     (abort),
        .pix_valid (accept),
        .pix       (iPixel),
        .clr_en    (state_q == CLEAR),
        .clr_addr  (clr_addr_q),
        .q         (ram.iQ),
        .addr_rd   (addr_rd),
        .addr_wr   (addr_wr),
        .data_wr   (data_wr),
        .we        (we)
    );

    assign ram.oAddrRd = addr_rd;
    assign ram.oAddrWr = addr_wr;
    assign ram.oDataWr = data_wr;
    assign ram.oWE     = we;

    assign oOwnRam     = (state_q != HANDOFF) && (state_q != WAIT_CUM);
    assign oStartCum   = (state_q == HANDOFF);
    assign oBusy       = (state_q != WAIT_FRAME);
    assign oCumRestart = cum_restart_q;
    assign oFrameErr   = frame_err_q;
endmodule

// File: tb/tb_histogram_accumulator.sv
// Bench for histogram_accumulator: RAM model, reference histogram, per-cycle compare.
module tb_histogram_accumulator;
    localparam int WS   = 10;
    localparam int NP   = 1536;
    localparam int MAXC = (1 << WS) - 1;

    logic          iClk;
    logic          iRst_n;
    logic          iFrameStart;
    logic          iPixValid;
    logic [7:0]    iPixel;
    logic          oOwnRam;
    logic          oStartCum;
    logic          iCumDone;
    logic          oCumRestart;
    logic          oFrameErr;
    logic          oBusy;
    logic          poison;
    logic [WS-1:0] mem [256];
    int            model [256];
    int            n_checks;
    int            n_pass;
    int            arm_req;

    histogram_accumulator_if #(.WORD_SIZE(WS)) bus ();

    histogram_accumulator #(
        .WORD_SIZE  (WS),
        .NUM_PIXELS (NP),
        .CNT_W      (11)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iFrameStart (iFrameStart),
        .iPixValid   (iPixValid),
        .iPixel      (iPixel),
        .ram         (bus),
        .oOwnRam     (oOwnRam),
        .oStartCum   (oStartCum),
        .iCumDone    (iCumDone),
        .oCumRestart (oCumRestart),
        .oFrameErr   (oFrameErr),
        .oBusy       (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Histogram RAM: one-cycle read latency, read-during-write returns old data.
    always @(posedge iClk) begin
        bus.iQ <= mem[bus.oAddrRd];
        if (poison) begin
            for (int i = 0; i < 256; i++) mem[i] <= WS'(341);
        end else if (bus.oWE) begin
            mem[bus.oAddrWr] <= bus.oDataWr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [7:0] pix_val(input int kind, input int i);
        case (kind)
            0:       return 8'(i % 256);
            1:       return 8'h7F;
            default: return 8'((i * 37 + 11) % 256);
        endcase
    endfunction

    // Per-cycle compare: clear write sequence after each clear entry, and no write while the RAM is released.
    task automatic compare_loop();
        int clr_pos  = -2;
        int arm_seen = 0;
        forever begin
            @(negedge iClk);
            if (!iRst_n) continue;
            if (arm_req != arm_seen) begin
                arm_seen = arm_req;
                clr_pos  = -1;
                chk("clr_lead_we", bus.oWE, 0);
            end else begin
                if (clr_pos == -1) clr_pos = 0;
                if (clr_pos >= 0) begin
                    chk($sformatf("clr_we[%0d]", clr_pos), bus.oWE, 1);
                    chk($sformatf("clr_addr[%0d]", clr_pos), bus.oAddrWr, clr_pos);
                    chk($sformatf("clr_data[%0d]", clr_pos), bus.oDataWr, 0);
                    chk($sformatf("clr_busy[%0d]", clr_pos), oBusy, (clr_pos == 255) ? 0 : 1);
                    clr_pos = (clr_pos == 255) ? -2 : clr_pos + 1;
                end
            end
            if (!oOwnRam) chk("we_not_owner", bus.oWE, 0);
        end
    endtask

    task automatic send_px(input bit fs, input bit pv, input logic [7:0] px);
        iFrameStart = fs;
        iPixValid   = pv;
        iPixel      = px;
        @(posedge iClk);
        #1;
        iFrameStart = 1'b0;
        iPixValid   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (oBusy && n < 400) begin
            @(posedge iClk);
            #1;
            n++;
        end
        chk("ready_idle", oBusy, 0);
    endtask

    task automatic check_handoff_and_bins(input string tag);
        send_px(0, 0, 8'd0);
        send_px(0, 0, 8'd0);
        chk({tag, "_start_early"}, oStartCum, 0);
        send_px(0, 0, 8'd0);
        chk({tag, "_start"}, oStartCum, 1);
        chk({tag, "_own_handoff"}, oOwnRam, 0);
        for (int b = 0; b < 256; b++) chk($sformatf("%s_bin[%0d]", tag, b), mem[b], sat(model[b]));
        send_px(0, 0, 8'd0);
        chk({tag, "_start_one"}, oStartCum, 0);
        chk({tag, "_own_wait"}, oOwnRam, 0);
    endtask

    task automatic run_frame(input int kind, input string tag);
        logic [7:0] seq [6] = '{8'd5, 8'd5, 8'd9, 8'd5, 8'd9, 8'd9};
        int         gap [6] = '{0, 1, 2, 0, 1, 2};
        logic [7:0] v;
        for (int b = 0; b < 256; b++) model[b] = 0;
        wait_idle();
        if (kind == 2) begin
            for (int k = 0; k < 6; k++) begin
                model[seq[k]]++;
                send_px(k == 0, 1, seq[k]);
                for (int g = 0; g < gap[k]; g++) send_px(0, 0, 8'd5);
            end
            for (int i = 6; i < NP; i++) begin
                model[200]++;
                send_px(0, 1, 8'd200);
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                v = pix_val(kind, i);
                model[v]++;
                send_px(i == 0, 1, v);
            end
        end
        check_handoff_and_bins(tag);
    endtask

    task automatic cum_phase(input int cycles, input string tag);
        int own_bad = 0;
        for (int c = 0; c < cycles; c++) begin
            send_px((c % 97) == 0, 1, 8'(c));
            if (oOwnRam) own_bad++;
        end
        chk({tag, "_own_held_low"}, own_bad, 0);
        chk({tag, "_no_restart_early"}, oCumRestart, 0);
        iCumDone = 1'b1;
        @(posedge iClk);
        #1;
        iCumDone = 1'b0;
        arm_req++;
        chk({tag, "_restart"}, oCumRestart, 1);
        chk({tag, "_own_back"}, oOwnRam, 1);
        send_px(0, 0, 8'd0);
        chk({tag, "_restart_one"}, oCumRestart, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        arm_req     = 0;
        poison      = 1'b1;
        iRst_n      = 1'b0;
        iFrameStart = 1'b0;
        iPixValid   = 1'b0;
        iPixel      = 8'd0;
        iCumDone    = 1'b0;
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        poison = 1'b0;
        arm_req++;
        chk("rst_own", oOwnRam, 1);
        chk("rst_busy", oBusy, 1);
        chk("rst_we", bus.oWE, 0);
        chk("rst_start", oStartCum, 0);
        chk("rst_restart", oCumRestart, 0);
        chk("rst_err", oFrameErr, 0);
        chk("rst_addr_rd", bus.oAddrRd, 0);
        chk("rst_addr_wr", bus.oAddrWr, 0);
        chk("rst_data_wr", bus.oDataWr, 0);

        run_frame(0, "ramp");
        chk("ramp_pin0", mem[0], 6);
        chk("ramp_pin255", mem[255], 6);
        chk("ramp_model_pin", sat(model[77]), 6);
        cum_phase(500, "cum_a");

        run_frame(1, "flat");
        chk("flat_pin127", mem[127], 1023);
        chk("flat_pin126", mem[126], 0);
        cum_phase(20, "cum_b");

        run_frame(2, "gaps");
        chk("gaps_pin5", mem[5], 3);
        chk("gaps_pin9", mem[9], 3);
        chk("gaps_pin200", mem[200], 1023);
        cum_phase(20, "cum_c");

        wait_idle();
        for (int i = 0; i < 1000; i++) send_px(i == 0, 1, pix_val(3, i));
        chk("abort_err_before", oFrameErr, 0);
        send_px(1, 1, 8'h33);
        arm_req++;
        chk("abort_err", oFrameErr, 1);
        chk("abort_busy", oBusy, 1);
        chk("abort_own", oOwnRam, 1);
        send_px(0, 0, 8'd0);
        chk("abort_err_one", oFrameErr, 0);

        run_frame(3, "after_abort");
        chk("after_abort_pin11", mem[11], 6);

        repeat (5) send_px(0, 1, 8'd1);
        iRst_n = 1'b0;
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        arm_req++;
        chk("midrst_restart", oCumRestart, 0);
        chk("midrst_own", oOwnRam, 1);
        chk("midrst_busy", oBusy, 1);
        chk("midrst_start", oStartCum, 0);
        wait_idle();
        send_px(0, 0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
